// File: rtl/tnn_psum_sequencer_pkg.sv
// Shared types and helpers for the ternary-NN partial-sum sequencer.
// The comparator operand width is fixed here so every consumer agrees on it.
package tnn_pkg;

  localparam int OP_W      = 3;
  localparam int CLAMP_MAX = (1 << OP_W) - 1;
  localparam int ACC_MAX_W = 16;

  localparam logic [1:0] W_POS  = 2'b01;
  localparam logic [1:0] W_NEG  = 2'b11;
  localparam logic [1:0] W_ZERO = 2'b00;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    EMIT
  } psum_state_t;

  function automatic logic [OP_W-1:0] clamp_u(input logic signed [ACC_MAX_W-1:0] acc);
    if (acc < 0) begin
      return '0;
    end else if (acc > CLAMP_MAX) begin
      return OP_W'(CLAMP_MAX);
    end else begin
      return acc[OP_W-1:0];
    end
  endfunction

endpackage

// File: rtl/tnn_psum_sequencer_if.sv
// Feature-in, config and operand-out bundle for the partial-sum sequencer.
// slave is the sequencer's view, master is the producer/consumer side.
interface tnn_psum_sequencer_if
  import tnn_pkg::*;
#(
  parameter int NID_W = 2
);

  logic             in_valid;
  logic             in_ready;
  logic             in_x;
  logic [1:0]       in_w;
  logic [NID_W-1:0] in_nid;
  logic             in_last;

  logic             cfg_we;
  logic [NID_W-1:0] cfg_addr;
  logic [OP_W-1:0]  cfg_thr;

  logic             op_valid;
  logic             op_ready;
  logic [OP_W-1:0]  op_a;
  logic [OP_W-1:0]  op_b;
  logic [OP_W-1:0]  op_c;
  logic [NID_W-1:0] op_nid;
  logic             op_err;

  modport slave (
    input  in_valid, in_x, in_w, in_nid, in_last,
    input  cfg_we, cfg_addr, cfg_thr,
    input  op_ready,
    output in_ready,
    output op_valid, op_a, op_b, op_c, op_nid, op_err
  );

  modport master (
    output in_valid, in_x, in_w, in_nid, in_last,
    output cfg_we, cfg_addr, cfg_thr,
    output op_ready,
    input  in_ready,
    input  op_valid, op_a, op_b, op_c, op_nid, op_err
  );

endinterface

// File: rtl/tnn_psum_sequencer_thr_table.sv
// Per-neuron threshold register file: one write port, one combinational read port.
// The async read lets the sequencer capture the pre-write value on a colliding edge.
module tnn_thr_table
  import tnn_pkg::*;
#(
  parameter int N_NEURONS = 4,
  localparam int NID_W    = $clog2(N_NEURONS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [NID_W-1:0] waddr_i,
  input  logic [OP_W-1:0]  wdata_i,
  input  logic [NID_W-1:0] raddr_i,
  output logic [OP_W-1:0]  rdata_o
);

  logic [OP_W-1:0] thr_q [N_NEURONS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NEURONS; i++) thr_q[i] <= '0;
    end else if (we_i) begin
      thr_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = thr_q[raddr_i];

endmodule

// File: rtl/tnn_psum_sequencer.sv
// Accumulates two clamped ternary partial sums per neuron frame and hands them,
// with the neuron's threshold, to the approximate comparator over valid/ready.
module tnn_psum_sequencer
  import tnn_pkg::*;
#(
  parameter int N_FEAT    = 12,
  parameter int N_NEURONS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tnn_psum_sequencer_if.slave  bus
);

  localparam int HALF  = N_FEAT / 2;
  localparam int IDX_W = $clog2(N_FEAT);
  localparam int ACC_W = $clog2(HALF + 1) + 1;
  localparam int NID_W = $clog2(N_NEURONS);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_FEAT - 1);
  localparam logic [IDX_W-1:0] IDX_HALF = IDX_W'(HALF);

  psum_state_t              state_q;
  logic [IDX_W-1:0]         idx_q;
  logic signed [ACC_W-1:0]  acc_a_q, acc_b_q;
  logic [NID_W-1:0]         nid_q;
  logic                     in_ready_q, op_valid_q, op_err_q;
  logic [OP_W-1:0]          op_a_q, op_b_q, op_c_q;
  logic [NID_W-1:0]         op_nid_q;

  logic signed [ACC_W-1:0]  beat_p;
  logic signed [ACC_W-1:0]  acc_a_d, acc_b_d;
  logic [NID_W-1:0]         nid_d;
  logic [OP_W-1:0]          thr_rdata;
  logic                     idx_is_last, beat_close;

  always_comb begin
    beat_p = '0;
    if (bus.in_x) begin
      case (bus.in_w)
        W_POS:   beat_p = {{(ACC_W-1){1'b0}}, 1'b1};
        W_NEG:   beat_p = '1;
        W_ZERO:  beat_p = '0;
        default: beat_p = '0;
      endcase
    end
  end

  assign idx_is_last = (idx_q == IDX_LAST);
  assign beat_close  = bus.in_last || idx_is_last;
  assign acc_a_d     = (idx_q <  IDX_HALF) ? acc_a_q + beat_p : acc_a_q;
  assign acc_b_d     = (idx_q >= IDX_HALF) ? acc_b_q + beat_p : acc_b_q;
  // The neuron id is only valid on the first beat; later beats reuse the latched one.
  assign nid_d       = (idx_q == '0) ? bus.in_nid : nid_q;

  tnn_thr_table #(.N_NEURONS(N_NEURONS)) u_thr_table (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (bus.cfg_we),
    .waddr_i (bus.cfg_addr),
    .wdata_i (bus.cfg_thr),
    .raddr_i (nid_d),
    .rdata_o (thr_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      acc_a_q    <= '0;
      acc_b_q    <= '0;
      nid_q      <= '0;
      in_ready_q <= 1'b0;
      op_valid_q <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_c_q     <= '0;
      op_nid_q   <= '0;
      op_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q    <= ACCUM;
          in_ready_q <= 1'b1;
        end
        ACCUM: begin
          if (bus.in_valid && in_ready_q) begin
            nid_q   <= nid_d;
            acc_a_q <= acc_a_d;
            acc_b_q <= acc_b_d;
            if (beat_close) begin
              state_q    <= EMIT;
              in_ready_q <= 1'b0;
              op_valid_q <= 1'b1;
              op_a_q     <= clamp_u(ACC_MAX_W'(acc_a_d));
              op_b_q     <= clamp_u(ACC_MAX_W'(acc_b_d));
              op_c_q     <= thr_rdata;
              op_nid_q   <= nid_d;
              op_err_q   <= (bus.in_last != idx_is_last);
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        EMIT: begin
          if (bus.op_ready) begin
            state_q    <= ACCUM;
            in_ready_q <= 1'b1;
            op_valid_q <= 1'b0;
            idx_q      <= '0;
            acc_a_q    <= '0;
            acc_b_q    <= '0;
          end
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b0;
          op_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.op_valid = op_valid_q;
  assign bus.op_a     = op_a_q;
  assign bus.op_b     = op_b_q;
  assign bus.op_c     = op_c_q;
  assign bus.op_nid   = op_nid_q;
  assign bus.op_err   = op_err_q;

endmodule

// File: tb/tb_tnn_psum_sequencer.sv
// Scoreboard bench for tnn_psum_sequencer: reference sums from plain arithmetic,
// a decoupled monitor pops expectations on every operand handshake.
module tb_tnn_psum_sequencer;
  import tnn_pkg::*;

  localparam int NF    = 12;
  localparam int HALF  = NF / 2;
  localparam int NN    = 4;
  localparam int NID_W = 2;

  typedef struct {
    int a;
    int b;
    int c;
    int nid;
    int err;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tnn_psum_sequencer_if #(.NID_W(NID_W)) bus ();
  tnn_psum_sequencer_if #(.NID_W(NID_W)) bus16 ();

  tnn_psum_sequencer #(.N_FEAT(NF), .N_NEURONS(NN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  tnn_psum_sequencer #(.N_FEAT(16), .N_NEURONS(NN)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16)
  );

  exp_t sbq[$];
  int   thr_m [NN];
  int   bx[$];
  int   bw[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   hold_rdy = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int clampi(input int v);
    if (v < 0) return 0;
    if (v > 7) return 7;
    return v;
  endfunction

  function automatic logic [1:0] enc(input int w);
    if (w > 0) return 2'b01;
    if (w < 0) return 2'b11;
    return ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00;
  endfunction

  // Comparator-side readiness: random unless a test pins it low.
  initial begin
    bus.op_ready   = 1'b0;
    bus16.op_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.op_ready = hold_rdy ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops on each handshake, and checks operands hold while stalled.
  logic       prev_stall = 1'b0;
  logic [2:0] pa, pb, pc;
  logic [1:0] pn;
  logic       pe;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.op_valid && prev_stall) begin
        chk("hold_op_a", int'(bus.op_a), int'(pa));
        chk("hold_op_b", int'(bus.op_b), int'(pb));
        chk("hold_op_c", int'(bus.op_c), int'(pc));
        chk("hold_op_nid", int'(bus.op_nid), int'(pn));
        chk("hold_op_err", int'(bus.op_err), int'(pe));
      end
      if (bus.op_valid && bus.op_ready) begin
        if (sbq.size() == 0) begin
          chk("unexpected_op_valid", 1, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("op_a", int'(bus.op_a), e.a);
          chk("op_b", int'(bus.op_b), e.b);
          chk("op_c", int'(bus.op_c), e.c);
          chk("op_nid", int'(bus.op_nid), e.nid);
          chk("op_err", int'(bus.op_err), e.err);
        end
      end
      prev_stall = bus.op_valid && !bus.op_ready;
      pa = bus.op_a; pb = bus.op_b; pc = bus.op_c; pn = bus.op_nid; pe = bus.op_err;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic drive_beat(input int x, input logic [1:0] w, input int nid, input bit last);
    int t;
    bus.in_valid = 1'b1;
    bus.in_x     = (x != 0);
    bus.in_w     = w;
    bus.in_nid   = NID_W'(nid);
    bus.in_last  = last;
    t = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      t++;
      if (t > 200) begin
        $display("FAIL beat_timeout: in_ready stuck at 0");
        $fatal(1);
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic rand_fill(input int len);
    bx.delete();
    bw.delete();
    for (int i = 0; i < len; i++) begin
      bx.push_back($urandom_range(0, 1));
      bw.push_back(int'($urandom_range(0, 2)) - 1);
    end
  endtask

  task automatic send_frame(input int nid, input int len, input bit last);
    exp_t e;
    int   sa, sb;
    sa = 0;
    sb = 0;
    for (int i = 0; i < len; i++) begin
      if (i < HALF) sa += (bx[i] != 0) ? bw[i] : 0;
      else          sb += (bx[i] != 0) ? bw[i] : 0;
    end
    e.a   = clampi(sa);
    e.b   = clampi(sb);
    e.c   = thr_m[nid];
    e.nid = nid;
    e.err = last ? int'(len != NF) : int'(len == NF);
    for (int i = 0; i < len; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      drive_beat(bx[i], enc(bw[i]), (i == 0) ? nid : int'($urandom_range(0, NN-1)),
                 last && (i == len - 1));
    end
    chk("latency_op_valid", int'(bus.op_valid), 1);
    sbq.push_back(e);
  endtask

  task automatic cfg_write(input int addr, input int val);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = NID_W'(addr);
    bus.cfg_thr  = 3'(val);
    @(posedge clk);
    #1;
    bus.cfg_we   = 1'b0;
    thr_m[addr]  = val;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sbq.size() != 0 || bus.op_valid) begin
      @(posedge clk);
      #1;
      t++;
      if (t > 1000) begin
        chk("drain_timeout", 1, 0);
        break;
      end
    end
  endtask

  task automatic beat16(input int w, input bit last);
    int t;
    bus16.in_valid = 1'b1;
    bus16.in_x     = 1'b1;
    bus16.in_w     = enc(w);
    bus16.in_last  = last;
    t = 0;
    forever begin
      @(negedge clk);
      if (bus16.in_ready) break;
      t++;
      if (t > 200) begin
        $display("FAIL beat16_timeout: in_ready stuck at 0");
        $fatal(1);
      end
    end
    @(posedge clk);
    #1;
    bus16.in_valid = 1'b0;
    bus16.in_last  = 1'b0;
  endtask

  initial begin
    int ok, len, r, nid;
    bus.in_valid = 0; bus.in_x = 0; bus.in_w = 0; bus.in_nid = 0; bus.in_last = 0;
    bus.cfg_we = 0; bus.cfg_addr = 0; bus.cfg_thr = 0;
    bus16.in_valid = 0; bus16.in_x = 0; bus16.in_w = 0; bus16.in_nid = 0; bus16.in_last = 0;
    bus16.cfg_we = 0; bus16.cfg_addr = 0; bus16.cfg_thr = 0;
    for (int i = 0; i < NN; i++) thr_m[i] = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", int'(bus.in_ready), 0);
    chk("rst_op_valid", int'(bus.op_valid), 0);
    chk("rst_op_abc", int'({bus.op_a, bus.op_b, bus.op_c}), 0);
    chk("rst_op_nid_err", int'({bus.op_nid, bus.op_err}), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic frame with preloaded threshold
    cfg_write(2, 5);
    bx.delete(); bw.delete();
    for (int i = 0; i < NF; i++) begin
      bx.push_back(1);
      bw.push_back(i < HALF ? 1 : 0);
    end
    send_frame(2, NF, 1'b1);

    // Mixed signs, including one x=0 beat
    bx = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1};
    bw = '{1, 1, -1, 0, 1, 1, -1, 1, 1, 1, 1, -1};
    send_frame(0, NF, 1'b1);

    // Lower clamp at NF=12
    bx.delete(); bw.delete();
    for (int i = 0; i < NF; i++) begin bx.push_back(1); bw.push_back(-1); end
    send_frame(3, NF, 1'b1);

    // Backpressure: stalled EMIT ignores beats and threshold writes
    drain();
    cfg_write(1, 3);
    hold_rdy = 1'b1;
    rand_fill(NF);
    send_frame(1, NF, 1'b1);
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1'b1;
      bus.in_x     = 1'b1;
      bus.in_w     = 2'b01;
      bus.in_nid   = 2'd0;
      if (k == 2) begin
        bus.cfg_we = 1'b1; bus.cfg_addr = 2'd1; bus.cfg_thr = 3'd6;
      end
      @(negedge clk);
      chk("stall_in_ready", int'(bus.in_ready), 0);
      chk("stall_op_valid", int'(bus.op_valid), 1);
      @(posedge clk);
      #1;
      bus.cfg_we = 1'b0;
    end
    bus.in_valid = 1'b0;
    thr_m[1] = 6;
    hold_rdy = 1'b0;

    // Length errors
    rand_fill(8);
    send_frame(2, 8, 1'b1);
    rand_fill(NF);
    send_frame(1, NF, 1'b0);
    rand_fill(NF);
    send_frame(0, NF, 1'b1);

    // Randomized traffic with interleaved threshold updates
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) == 0) cfg_write($urandom_range(0, NN-1), $urandom_range(0, 7));
      r   = $urandom_range(0, 9);
      nid = $urandom_range(0, NN-1);
      if (r < 6)      begin len = NF; rand_fill(len); send_frame(nid, len, 1'b1); end
      else if (r < 8) begin len = $urandom_range(1, NF-1); rand_fill(len); send_frame(nid, len, 1'b1); end
      else            begin len = NF; rand_fill(len); send_frame(nid, len, 1'b0); end
    end
    drain();

    // Upper and lower clamp with 8-beat halves
    for (int i = 0; i < 16; i++) beat16(1, i == 15);
    chk("n16_latency", int'(bus16.op_valid), 1);
    chk("n16_pos_op_a", int'(bus16.op_a), 7);
    chk("n16_pos_op_b", int'(bus16.op_b), 7);
    chk("n16_pos_op_err", int'(bus16.op_err), 0);
    for (int i = 0; i < 16; i++) beat16(-1, i == 15);
    chk("n16_neg_op_a", int'(bus16.op_a), 0);
    chk("n16_neg_op_b", int'(bus16.op_b), 0);
    chk("n16_neg_op_err", int'(bus16.op_err), 0);

    // Reset on beat 4 discards the frame and clears the table
    cfg_write(2, 6);
    drain();
    for (int i = 0; i < 4; i++) drive_beat(1, 2'b01, 2, 1'b0);
    bus.in_valid = 1'b1; bus.in_x = 1'b1; bus.in_w = 2'b01;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    chk("midrst_in_ready", int'(bus.in_ready), 0);
    chk("midrst_op_c", int'(bus.op_c), 0);
    rst_n = 1'b1;
    for (int i = 0; i < NN; i++) thr_m[i] = 0;
    ok = 1;
    repeat (10) begin
      @(negedge clk);
      if (bus.op_valid) ok = 0;
    end
    chk("midrst_no_op_valid", ok, 1);
    bx.delete(); bw.delete();
    for (int i = 0; i < NF; i++) begin bx.push_back(1); bw.push_back(i < 4 ? 1 : -1); end
    send_frame(2, NF, 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
